// File: rtl/chess_video_pkg.sv
// Shared types for the chess video path: pixel colour, layer identifiers and
// the encoding of the turn-indicator blink state.
package chess_video_pkg;

  typedef logic [11:0] rgb12_t;

  localparam rgb12_t KEY_COLOR_DEFAULT = 12'hF0F;

  typedef enum logic [1:0] {
    L_BOARD  = 2'd0,
    L_PIECE  = 2'd1,
    L_HILITE = 2'd2,
    L_TURN   = 2'd3
  } layer_e;

  // Encoded so that the state bit is the visibility flag itself.
  typedef enum logic {
    HID = 1'b0,
    VIS = 1'b1
  } blink_state_e;

endpackage

// File: rtl/blink_timer.sv
// Frame-counting blink timer: toggles turn-layer visibility every BLINK_FRAMES
// vsync falling edges while blink_en is high, and holds it visible otherwise.
module blink_timer
  import chess_video_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic vga_clk,
  input  logic rst_n,
  input  logic vsync_in,
  input  logic blink_en,
  output logic blink_vis
);

  localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

  blink_state_e state, state_next;
  logic [7:0]   frame_cnt, frame_cnt_next;
  logic         vsync_prev;
  logic         fe;

  assign fe        = vsync_prev & ~vsync_in;
  assign blink_vis = (state == VIS);

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= VIS;
      frame_cnt  <= 8'd0;
      vsync_prev <= 1'b1;
    end else begin
      state      <= state_next;
      frame_cnt  <= frame_cnt_next;
      vsync_prev <= vsync_in;
    end
  end

  // Disabling wins over a coincident frame edge so the layer is steady at once.
  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    if (!blink_en) begin
      state_next     = VIS;
      frame_cnt_next = 8'd0;
    end else if (fe) begin
      if (frame_cnt == LAST_FRAME) begin
        frame_cnt_next = 8'd0;
        state_next     = (state == VIS) ? HID : VIS;
      end else begin
        frame_cnt_next = frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/overlay_compositor.sv
// Merges board, piece, highlight and turn-indicator layers into one registered
// RGB444 pixel with colour-key transparency, fixed priority and aligned syncs.
module overlay_compositor
  import chess_video_pkg::*;
#(
  parameter int     BLINK_FRAMES = 30,
  parameter rgb12_t KEY_COLOR    = KEY_COLOR_DEFAULT
) (
  input  logic         vga_clk,
  input  logic         rst_n,
  input  logic         blank,
  input  logic         hsync_in,
  input  logic         vsync_in,
  input  logic         blink_en,
  input  logic [11:0]  board_rgb,
  input  logic         piece_on,
  input  logic [11:0]  piece_rgb,
  input  logic         hilite_on,
  input  logic [11:0]  hilite_rgb,
  input  logic         turn_on,
  input  logic [11:0]  turn_rgb,
  output logic [3:0]   red,
  output logic [3:0]   green,
  output logic [3:0]   blue,
  output logic         hsync_out,
  output logic         vsync_out,
  output logic         active_out,
  output layer_e       win_layer
);

  logic   blink_vis;
  logic   piece_opq, hilite_opq, turn_opq;
  rgb12_t mix_rgb;
  layer_e mix_layer;

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .vga_clk  (vga_clk),
    .rst_n    (rst_n),
    .vsync_in (vsync_in),
    .blink_en (blink_en),
    .blink_vis(blink_vis)
  );

  assign piece_opq  = piece_on  && (piece_rgb  != KEY_COLOR);
  assign hilite_opq = hilite_on && (hilite_rgb != KEY_COLOR);
  assign turn_opq   = turn_on   && (turn_rgb   != KEY_COLOR) && blink_vis;

  // Board is the fallback and is never keyed out.
  always_comb begin
    mix_rgb   = board_rgb;
    mix_layer = L_BOARD;
    if (turn_opq) begin
      mix_rgb   = turn_rgb;
      mix_layer = L_TURN;
    end else if (hilite_opq) begin
      mix_rgb   = hilite_rgb;
      mix_layer = L_HILITE;
    end else if (piece_opq) begin
      mix_rgb   = piece_rgb;
      mix_layer = L_PIECE;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      red        <= 4'd0;
      green      <= 4'd0;
      blue       <= 4'd0;
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
      active_out <= 1'b0;
      win_layer  <= L_BOARD;
    end else begin
      red        <= blank ? mix_rgb[11:8] : 4'd0;
      green      <= blank ? mix_rgb[7:4]  : 4'd0;
      blue       <= blank ? mix_rgb[3:0]  : 4'd0;
      hsync_out  <= hsync_in;
      vsync_out  <= vsync_in;
      active_out <= blank;
      win_layer  <= mix_layer;
    end
  end

endmodule

// File: tb/tb_overlay_compositor.sv
// Bench for overlay_compositor: expected pixels are queued when inputs are
// driven and compared one cycle later against the registered outputs.
module tb_overlay_compositor;
  import chess_video_pkg::*;

  localparam int     BF  = 2;
  localparam rgb12_t KEY = 12'hF0F;

  // ---------------- clock / reset ----------------
  logic vga_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic         blank, hsync_in, vsync_in, blink_en;
  logic [11:0]  board_rgb, piece_rgb, hilite_rgb, turn_rgb;
  logic         piece_on, hilite_on, turn_on;
  logic [3:0]   red, green, blue;
  logic         hsync_out, vsync_out, active_out;
  layer_e       win_layer;

  overlay_compositor #(.BLINK_FRAMES(BF), .KEY_COLOR(KEY)) dut (
    .vga_clk   (vga_clk),
    .rst_n     (rst_n),
    .blank     (blank),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .blink_en  (blink_en),
    .board_rgb (board_rgb),
    .piece_on  (piece_on),
    .piece_rgb (piece_rgb),
    .hilite_on (hilite_on),
    .hilite_rgb(hilite_rgb),
    .turn_on   (turn_on),
    .turn_rgb  (turn_rgb),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .active_out(active_out),
    .win_layer (win_layer)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {layer[1:0], active, hsync, vsync, rgb[11:0]}
  logic [16:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference blink model: frame edges counted since blink was enabled.
  int   m_edges   = 0;
  logic m_vs_prev = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"},    {20'd0, red, green, blue}, 32'h0);
    check({tag, "_syncs"},  {30'd0, hsync_out, vsync_out}, 32'h3);
    check({tag, "_active"}, {31'd0, active_out}, 32'h0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic        vis, fe;
    logic [11:0] px;
    logic [1:0]  lyr;
    logic [16:0] exp, got;
    vis = ((m_edges / BF) % 2) == 0;
    px  = board_rgb;
    lyr = 2'd0;
    if (turn_on && turn_rgb != KEY && vis) begin
      px = turn_rgb;  lyr = 2'd3;
    end else if (hilite_on && hilite_rgb != KEY) begin
      px = hilite_rgb; lyr = 2'd2;
    end else if (piece_on && piece_rgb != KEY) begin
      px = piece_rgb; lyr = 2'd1;
    end
    if (!blank) px = 12'h000;
    exp_q.push_back({lyr, blank, hsync_in, vsync_in, px});
    @(posedge vga_clk);
    fe = m_vs_prev && !vsync_in;
    if (!blink_en) m_edges = 0;
    else if (fe)   m_edges++;
    m_vs_prev = vsync_in;
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      got = {win_layer, active_out, hsync_out, vsync_out, red, green, blue};
      check("rgb",    {20'd0, got[11:0]},  {20'd0, exp[11:0]});
      check("syncs",  {30'd0, got[13:12]}, {30'd0, exp[13:12]});
      check("active", {31'd0, got[14]},    {31'd0, exp[14]});
      check("layer",  {30'd0, got[16:15]}, {30'd0, exp[16:15]});
    end
  endtask

  task automatic set_layers(input logic [11:0] brd,
                            input logic pon, input logic [11:0] prgb,
                            input logic hon, input logic [11:0] hrgb,
                            input logic ton, input logic [11:0] trgb);
    board_rgb = brd;
    piece_on  = pon; piece_rgb  = prgb;
    hilite_on = hon; hilite_rgb = hrgb;
    turn_on   = ton; turn_rgb   = trgb;
  endtask

  task automatic randomize_inputs();
    blank      = 1'($urandom_range(0, 1));
    hsync_in   = 1'($urandom_range(0, 1));
    vsync_in   = 1'($urandom_range(0, 1));
    board_rgb  = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
    piece_on   = 1'($urandom_range(0, 1));
    piece_rgb  = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
    hilite_on  = 1'($urandom_range(0, 1));
    hilite_rgb = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
    turn_on    = 1'($urandom_range(0, 1));
    turn_rgb   = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
  endtask

  // One frame: short vsync pulse, then active lines.
  task automatic frame();
    vsync_in = 1'b0;
    repeat (2) begin hsync_in = 1'($urandom_range(0, 1)); tick(); end
    vsync_in = 1'b1;
    repeat (4) begin hsync_in = 1'($urandom_range(0, 1)); tick(); end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    blink_en = 1'b0;
    randomize_inputs();

    // Reset held with random inputs
    repeat (3) begin
      @(posedge vga_clk); #1;
      check_reset_outputs("reset_hold");
      randomize_inputs();
    end
    rst_n = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1;

    // Priority
    blank = 1'b1;
    set_layers(12'h111, 1, 12'h222, 1, 12'h333, 1, 12'h444); tick();
    set_layers(12'h111, 1, 12'h222, 1, 12'h333, 0, 12'h444); tick();
    set_layers(12'h111, 1, 12'h222, 0, 12'h333, 0, 12'h444); tick();

    // Colour key
    set_layers(12'h0A0, 1, KEY, 0, 12'h333, 0, 12'h444); tick();
    set_layers(KEY,     0, 12'h222, 0, 12'h333, 0, 12'h444); tick();
    set_layers(12'h111, 1, 12'h222, 1, KEY, 1, KEY); tick();

    // Blanking and sync delay
    set_layers(12'h111, 1, 12'h222, 1, 12'h333, 1, 12'h444);
    blank = 1'b0;
    for (int i = 0; i < 6; i++) begin
      hsync_in = i[0];
      vsync_in = i[1];
      tick();
    end
    blank = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; tick();

    // Blink: seven frames, toggling every BF edges
    set_layers(12'h111, 0, 12'h222, 0, 12'h333, 1, 12'h444);
    blink_en = 1'b1;
    tick();
    repeat (7) frame();

    // Disable on a frame edge while hidden, then re-enable
    blink_en = 1'b0; tick();
    blink_en = 1'b1;
    repeat (2) frame();              // now hidden
    vsync_in = 1'b0; blink_en = 1'b0; tick();
    vsync_in = 1'b1; tick(); tick();
    blink_en = 1'b1;
    repeat (4) frame();

    // Random traffic with blink running
    for (int i = 0; i < 200; i++) begin
      randomize_inputs();
      blink_en = ($urandom_range(0, 15) != 0);
      tick();
    end

    // Asynchronous reset mid-frame
    blank = 1'b1; set_layers(12'h111, 1, 12'h222, 1, 12'h333, 1, 12'h444);
    tick();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    m_edges = 0; m_vs_prev = 1'b1;
    @(posedge vga_clk); #1;
    check_reset_outputs("async_reset_held");
    rst_n = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (4) frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
